// File: rtl/issue_stage_pkg.sv
// rtl/issue_stage_pkg.sv - shared types and constants for the in-order issue stage
//
// Contents:
//   NUM_REGS_DEF    architectural register count the instruction format is sized for
//   REG_IDX_W       register index width, $clog2(NUM_REGS_DEF)
//   decoded_instr_t decoded instruction as held in the dispatch queue

package issue_stage_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int REG_IDX_W    = $clog2(NUM_REGS_DEF);

    typedef struct packed {
        logic [6:0]           opcode;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic                 uses_rs1;
        logic                 uses_rs2;
        logic                 writes_rd;
        logic [15:0]          imm;
    } decoded_instr_t;

endpackage

// File: rtl/issue_stage_scoreboard.sv
// rtl/issue_stage_scoreboard.sv - register busy scoreboard with writeback bypass
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   set_en, set_idx   mark a register busy (an instruction writing it was issued)
//   clr_en, clr_idx   mark a register ready (writeback)
//   clear_all         flush: every register ready, overrides set and clear
//   rd_*_idx          three read ports (rs1, rs2, rd of the queue head)
//   rd_*_busy         effective busy: a same-cycle writeback already counts as ready
//
// Register 0 is never busy. When the same register is set and cleared in one
// cycle the set wins, since the new writer is younger than the retiring one.

module issue_stage_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             clear_all,
    input  logic [IDX_W-1:0] rd_a_idx,
    input  logic [IDX_W-1:0] rd_b_idx,
    input  logic [IDX_W-1:0] rd_c_idx,
    output logic             rd_a_busy,
    output logic             rd_b_busy,
    output logic             rd_c_busy
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [NUM_REGS-1:0] busy_eff;

    always_comb begin
        busy_nxt = busy;
        if (clr_en) begin
            busy_nxt[clr_idx] = 1'b0;
        end
        // applied after the clear so that set wins on a collision
        if (set_en) begin
            busy_nxt[set_idx] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear_all) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // writeback bypass: the register being written back this cycle is ready now
    always_comb begin
        busy_eff = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_eff[i] = busy[i] & ~(clr_en && (clr_idx == IDX_W'(i)));
        end
        busy_eff[0] = 1'b0;
    end

    assign rd_a_busy = busy_eff[rd_a_idx];
    assign rd_b_busy = busy_eff[rd_b_idx];
    assign rd_c_busy = busy_eff[rd_c_idx];

endmodule

// File: rtl/issue_stage.sv
// rtl/issue_stage.sv - in-order issue stage: hazard check, pop, single issue register
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   dq_empty       dispatch queue empty
//   dq_instr       queue head, valid while dq_empty=0
//   dq_r_en        pop request (combinational); head advances at the next edge
//   issue_valid    issue register holds an instruction
//   issue_instr    instruction being issued
//   issue_ready    execution side accepts issue_instr this cycle
//   wb_valid       writeback event
//   wb_rd          register being written back
//   flush          drop the issue register and clear the scoreboard
//   stall_cnt      cycles with a head present but blocked by a hazard
//
// The head is popped only when it has no RAW/WAW hazard and the issue register
// is empty or being drained this cycle, so a ready consumer sees one issue per
// cycle with no bubble. NUM_REGS must match the instruction format's register
// index width.

import issue_stage_pkg::*;

module issue_stage #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        dq_empty,
    input  decoded_instr_t              dq_instr,
    output logic                        dq_r_en,
    output logic                        issue_valid,
    output decoded_instr_t              issue_instr,
    input  logic                        issue_ready,
    input  logic                        wb_valid,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd,
    input  logic                        flush,
    output logic [CNT_W-1:0]            stall_cnt
);

    logic busy_rs1;
    logic busy_rs2;
    logic busy_rd;
    logic hazard;
    logic slot_free;
    logic rd_nonzero;
    logic set_busy;

    assign rd_nonzero = (dq_instr.rd != '0);

    // an x0 writer never occupies the scoreboard
    assign set_busy = dq_r_en & dq_instr.writes_rd & rd_nonzero;

    issue_stage_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (set_busy),
        .set_idx   (dq_instr.rd),
        .clr_en    (wb_valid),
        .clr_idx   (wb_rd),
        .clear_all (flush),
        .rd_a_idx  (dq_instr.rs1),
        .rd_b_idx  (dq_instr.rs2),
        .rd_c_idx  (dq_instr.rd),
        .rd_a_busy (busy_rs1),
        .rd_b_busy (busy_rs2),
        .rd_c_busy (busy_rd)
    );

    // the rd term holds back a second writer (WAW) until the first retires
    assign hazard = (dq_instr.uses_rs1 & busy_rs1)
                  | (dq_instr.uses_rs2 & busy_rs2)
                  | (dq_instr.writes_rd & rd_nonzero & busy_rd);

    assign slot_free = ~issue_valid | issue_ready;

    assign dq_r_en = rst_n & ~flush & ~dq_empty & ~hazard & slot_free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_valid <= 1'b0;
            issue_instr <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else if (dq_r_en) begin
            issue_valid <= 1'b1;
            issue_instr <= dq_instr;
        end else if (issue_valid && issue_ready) begin
            issue_valid <= 1'b0;
        end
    end

    // free-running: wraps naturally and survives flush
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!dq_empty && hazard && !flush) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_issue_stage.sv
// tb/tb_issue_stage.sv - scoreboard bench for issue_stage with a reference model

import issue_stage_pkg::*;

module tb_issue_stage;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           dq_empty;
    decoded_instr_t dq_instr;
    logic           dq_r_en;
    logic           issue_valid;
    decoded_instr_t issue_instr;
    logic           issue_ready;
    logic           wb_valid;
    logic [4:0]     wb_rd;
    logic           flush;
    logic [31:0]    stall_cnt;

    issue_stage #(.NUM_REGS(32), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dq_empty    (dq_empty),
        .dq_instr    (dq_instr),
        .dq_r_en     (dq_r_en),
        .issue_valid (issue_valid),
        .issue_instr (issue_instr),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .flush       (flush),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // drive requests for the next cycle
    bit d_rst, d_flush, d_ready, d_wbv, d_hold_empty;
    int d_wbrd;

    // reference model state
    decoded_instr_t dq_list[$];
    decoded_instr_t exp_q[$];
    bit             m_busy[32];
    bit             m_valid;
    int unsigned    m_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic decoded_instr_t mk(int r1, bit u1, int r2, bit u2, int rd, bit w);
        decoded_instr_t i;
        i.opcode    = 7'($urandom);
        i.imm       = 16'($urandom);
        i.rs1       = 5'(r1);
        i.rs2       = 5'(r2);
        i.rd        = 5'(rd);
        i.uses_rs1  = u1;
        i.uses_rs2  = u2;
        i.writes_rd = w;
        return i;
    endfunction

    // a register still waits for its writer unless it is x0 or is written back right now
    function automatic bit still_busy(int r);
        return (r != 0) && m_busy[r] && !(d_wbv && d_wbrd == r);
    endfunction

    function automatic bit blocked(decoded_instr_t i);
        return (i.uses_rs1 && still_busy(int'(i.rs1)))
            || (i.uses_rs2 && still_busy(int'(i.rs2)))
            || (i.writes_rd && i.rd != 0 && still_busy(int'(i.rd)));
    endfunction

    task automatic step();
        bit empty, haz, exp_pop;
        @(posedge clk);
        #1;
        rst_n       = d_rst;
        flush       = d_flush;
        issue_ready = d_ready;
        wb_valid    = d_wbv;
        wb_rd       = 5'(d_wbrd);
        empty       = (dq_list.size() == 0) || d_hold_empty;
        dq_empty    = empty;
        dq_instr    = empty ? decoded_instr_t'({$urandom, $urandom}) : dq_list[0];
        haz         = !empty && blocked(dq_list[0]);
        exp_pop     = d_rst && !d_flush && !empty && !haz && (!m_valid || d_ready);

        @(negedge clk);
        chk("dq_r_en", dq_r_en, exp_pop);
        chk("issue_valid", issue_valid, m_valid);
        chk("stall_cnt", stall_cnt, m_stall);

        // model update once the monitor has seen this cycle's handshake
        #1;
        if (!d_rst) begin
            m_valid = 0;
            m_stall = 0;
            foreach (m_busy[r]) m_busy[r] = 0;
            exp_q.delete();
        end else if (d_flush) begin
            m_valid = 0;
            foreach (m_busy[r]) m_busy[r] = 0;
            exp_q.delete();
            dq_list.delete();
        end else begin
            if (haz) m_stall++;
            if (d_wbv) m_busy[d_wbrd] = 0;
            if (exp_pop) begin
                decoded_instr_t h;
                h = dq_list.pop_front();
                exp_q.push_back(h);
                m_valid = 1;
                if (h.writes_rd && h.rd != 0) m_busy[h.rd] = 1;
            end else if (m_valid && d_ready) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic drv(bit rst, bit fl, bit rdy, bit wbv, int wbrd);
        d_rst = rst; d_flush = fl; d_ready = rdy; d_wbv = wbv; d_wbrd = wbrd; d_hold_empty = 0;
    endtask

    // monitor: compare the presented instruction against the oldest expected issue
    initial begin
        forever begin
            @(negedge clk);
            if (issue_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("issue_unexpected", 1, 0);
                end else begin
                    chk("issue_instr", issue_instr, exp_q[0]);
                    if (issue_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int s0;
        rst_n = 0; flush = 0; issue_ready = 0; wb_valid = 0; wb_rd = 0;
        dq_empty = 1; dq_instr = '0;
        m_valid = 0; m_stall = 0;
        foreach (m_busy[r]) m_busy[r] = 0;
        repeat (2) @(posedge clk);

        // reset held with a head present, then first head issues
        dq_list.push_back(mk(0, 0, 0, 0, 1, 1));
        drv(0, 0, 1, 0, 0); step(); step();
        drv(1, 0, 1, 0, 0); step(); step();

        // independent stream x1..x4
        drv(1, 1, 1, 0, 0); step();
        for (int r = 1; r <= 4; r++) dq_list.push_back(mk(0, 1, 0, 1, r, 1));
        drv(1, 0, 1, 0, 0); repeat (5) step();
        dq_list.push_back(mk(3, 1, 0, 0, 9, 1));   // reads x3: must stall
        step(); step();
        drv(1, 0, 1, 1, 3); step();
        drv(1, 0, 1, 0, 0); step();

        // RAW stall on x5 with bypassed writeback
        drv(1, 1, 1, 0, 0); step();
        dq_list.push_back(mk(0, 0, 0, 0, 5, 1));
        dq_list.push_back(mk(5, 1, 0, 0, 6, 1));
        drv(1, 0, 1, 0, 0); step(); step();
        s0 = int'(stall_cnt);
        step(); step();
        drv(1, 0, 1, 1, 5); step();
        drv(1, 0, 1, 0, 0); step();
        chk("raw_stall_delta", 32'(stall_cnt - 32'(s0)), 32'd3);

        // backpressure then bubble-free handover
        drv(1, 1, 1, 0, 0); step();
        dq_list.push_back(mk(0, 0, 0, 0, 8, 1));
        dq_list.push_back(mk(0, 0, 0, 0, 10, 1));
        drv(1, 0, 1, 0, 0); step();
        drv(1, 0, 0, 0, 0); repeat (5) step();
        drv(1, 0, 1, 0, 0); step(); step(); step();

        // set/clear collision on x7, x0 writer, wb to x0
        drv(1, 1, 1, 0, 0); step();
        dq_list.push_back(mk(0, 0, 0, 0, 7, 1));
        dq_list.push_back(mk(7, 1, 0, 0, 0, 0));
        drv(1, 0, 1, 1, 7); step();
        drv(1, 0, 1, 0, 0); step(); step();
        drv(1, 0, 1, 1, 7); step();
        drv(1, 0, 1, 0, 0); step();
        dq_list.push_back(mk(0, 0, 0, 0, 0, 1));
        dq_list.push_back(mk(0, 1, 0, 1, 0, 1));
        drv(1, 0, 1, 1, 0); step(); step(); step();

        // flush while stalled on x3, writeback in the flush cycle
        drv(1, 1, 1, 0, 0); step();
        dq_list.push_back(mk(0, 0, 0, 0, 3, 1));
        dq_list.push_back(mk(3, 1, 3, 1, 4, 1));
        drv(1, 0, 0, 0, 0); step(); step(); step();
        drv(1, 1, 0, 1, 3); step();
        dq_list.push_back(mk(3, 1, 0, 0, 3, 1));
        drv(1, 0, 1, 0, 0); step(); step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (dq_list.size() < 3 && $urandom_range(0, 3) != 0)
                dq_list.push_back(mk($urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7),
                                     1'($urandom), $urandom_range(0, 7), 1'($urandom)));
            d_rst        = ($urandom_range(0, 199) != 0);
            d_flush      = ($urandom_range(0, 49) == 0);
            d_ready      = ($urandom_range(0, 9) < 7);
            d_wbv        = ($urandom_range(0, 9) < 4);
            d_wbrd       = $urandom_range(0, 7);
            d_hold_empty = ($urandom_range(0, 9) == 0);
            step();
        end

        drv(1, 0, 1, 0, 0); dq_list.delete(); step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- In-order issue stage: the read-side consumer of the dispatch queue.
- Inspects the queue head (combinational head data plus `empty`), checks a 32-entry register scoreboard for RAW/WAW hazards, and pops the head into a single issue register.
- Presents the issue register to the execution units over a valid/ready handshake.
- Clears scoreboard bits on writeback; supports a pipeline flush.

Parameters:
- NUM_REGS, 32, architectural register count; scoreboard width.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- dq_empty  in  1  dispatch queue empty
- dq_instr  in  decoded_instr_t  queue head; valid whenever dq_empty=0, combinational from queue read pointer
- dq_r_en  out  1  pop request to queue; head advances at the next clk edge
- issue_valid  out  1  issue register holds an instruction
- issue_instr  out  decoded_instr_t  instruction being issued
- issue_ready  in  1  execution side accepts issue_instr this cycle
- wb_valid  in  1  writeback event
- wb_rd  in  $clog2(NUM_REGS)  destination register being written back
- flush  in  1  discard in-flight issue state and clear scoreboard
- stall_cnt  out  CNT_W  cycles where the head was present but blocked by a hazard

Behaviour:
- Reset (rst_n=0 at posedge): issue_valid=0, issue_instr=0, scoreboard all 0, stall_cnt=0. dq_r_en is combinational and is 0 while rst_n=0.
- decoded_instr_t fields used: rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd.
- busy_eff[r] = busy[r] & ~(wb_valid & wb_rd==r). Writeback in the same cycle counts as ready (bypass). busy_eff[0]=0 always.
- hazard = (uses_rs1 & busy_eff[rs1]) | (uses_rs2 & busy_eff[rs2]) | (writes_rd & rd!=0 & busy_eff[rd]). The rd term blocks WAW.
- slot_free = ~issue_valid | issue_ready.
- dq_r_en = rst_n & ~flush & ~dq_empty & ~hazard & slot_free.
- Issue register update:
  - On dq_r_en: issue_instr<=dq_instr, issue_valid<=1.
  - Else if issue_valid & issue_ready: issue_valid<=0.
  - Else: hold; issue_instr stays stable while issue_valid=1 and issue_ready=0.
- Latency: head present in cycle N with no hazard and a free slot gives issue_valid=1 in cycle N+1. Back-to-back independent instructions sustain 1 issue per cycle with issue_ready held high.
- Scoreboard, per clk:
  - wb_valid clears busy[wb_rd].
  - On pop with writes_rd & rd!=0, set busy[rd].
  - Same-cycle set and clear of the same rd: set wins.
  - wb_valid with wb_rd=0, or for an already-clear register: no effect.
- Implicit states, derived from issue_valid and hazard (no extra encoding): EMPTY (issue_valid=0), HOLD (issue_valid=1, issue_ready=0), STALL (head present, hazard=1).
- stall_cnt increments when ~dq_empty & hazard & ~flush. It wraps modulo 2^CNT_W and is not cleared by flush.
- Flush (synchronous, priority over everything except reset): issue_valid<=0, scoreboard<=0, dq_r_en=0 that cycle. A wb_valid in the flush cycle is discarded. The queue itself is cleared by its owner.
- dq_r_en is never asserted when dq_empty=1.

Decomposition:
- define.svh (shared): decoded_instr_t (existing) and the REG_IDX_W constant = $clog2(NUM_REGS).
- Sub-module scoreboard:
  - Inputs: set_en, set_idx, clr_en, clr_idx, clear_all.
  - Outputs: three combinational read ports returning busy_eff.
  - Behaviour: register 0 hard-wired 0; set-over-clear priority.
- issue_stage contains the issue register, the hazard/pop logic and stall_cnt.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with dq_empty=0 -> dq_r_en=0, issue_valid=0, stall_cnt=0; after release, first head issues in cycle+1.
- Independent stream: 4 instrs writing x1..x4, sources x0, issue_ready=1 -> dq_r_en high 4 consecutive cycles, issue_valid high 4 cycles, busy[1..4]=1, stall_cnt=0.
- RAW stall: instr A writes x5, then B reads x5 -> B held, stall_cnt counts 3 over 3 cycles; wb_valid=1, wb_rd=5 -> dq_r_en=1 in that same cycle (bypass), B issues next cycle.
- Backpressure: issue_valid=1, issue_ready=0 for 5 cycles -> issue_instr stable, dq_r_en=0; issue_ready=1 with next head ready -> handover with no bubble.
- Set/clear collision: pop instr writing x7 in the same cycle as wb_rd=7 -> busy[7]=1 afterwards; an x0 writer never sets busy; wb_rd=0 is ignored.
- Flush mid-stall: busy[3]=1 with head stalled on x3, assert flush -> next cycle issue_valid=0 and scoreboard all 0; stall_cnt keeps its value; a wb_valid arriving in the flush cycle is dropped.
